// File: rtl/mem_mp_if.sv
// Request/response bundle for mem_mp: per-port read channels, one write channel, clear request.
// Latency: none of its own; it only carries signals.
// Backpressure: none; the master watches ready, and requests made while it is low are dropped.
interface mem_mp_if #(
  parameter int NUM_RD    = 2,
  parameter int ADDRWIDTH = 32,
  parameter int BUSWIDTH  = 32
);
  logic [NUM_RD-1:0]                rd_en;
  logic [NUM_RD-1:0][ADDRWIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][BUSWIDTH-1:0]  rd_data;
  logic [NUM_RD-1:0]                rd_valid;
  logic [NUM_RD-1:0]                rd_err;
  logic                             wr_en;
  logic [ADDRWIDTH-1:0]             wr_addr;
  logic [BUSWIDTH-1:0]              wr_data;
  logic [BUSWIDTH/8-1:0]            wr_be;
  logic                             wr_err;
  logic                             clr_req;
  logic                             ready;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be, clr_req,
    input  rd_data, rd_valid, rd_err, wr_err, ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be, clr_req,
    output rd_data, rd_valid, rd_err, wr_err, ready
  );
endinterface

// File: rtl/mem_mp.sv
// Multi-port behavioural memory: NUM_RD read ports, one byte-enabled write port, clear sweep.
// Latency: read data is RD_LATENCY registered stages after the issue edge; wr_err comes one cycle after the write.
// Backpressure: none; requests are accepted only while ready is high, and during a clear sweep they are dropped.
module mem_mp #(
  parameter int RAMDEPTH   = 1024,
  parameter int BUSWIDTH   = 32,
  parameter int ADDRWIDTH  = 32,
  parameter int NUM_RD     = 2,
  parameter int RD_LATENCY = 1,
  parameter int WR_MODE    = 0
) (
  input logic     clk,
  input logic     rst,
  mem_mp_if.slave bus
);
  localparam int IW = (RAMDEPTH > 1) ? $clog2(RAMDEPTH) : 1;
  localparam int NB = BUSWIDTH / 8;
  localparam logic [ADDRWIDTH-1:0] DEPTH_A  = ADDRWIDTH'(RAMDEPTH);
  localparam logic [IW-1:0]        LAST_IDX = IW'(RAMDEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic          wr_err_q;

  logic [BUSWIDTH-1:0] local_mem [RAMDEPTH];

  logic                            is_ready;
  logic                            wr_oor;
  logic                            wr_ok;
  logic [IW-1:0]                   wr_idx;
  logic [BUSWIDTH-1:0]             wr_word;
  logic [NUM_RD-1:0]               issue;
  logic [NUM_RD-1:0]               rd_oor;
  logic [NUM_RD-1:0][BUSWIDTH-1:0] rd_samp;

  // Stage 0 is loaded at the issue edge; the last stage drives the outputs.
  logic [RD_LATENCY-1:0][NUM_RD-1:0]               vld_q;
  logic [RD_LATENCY-1:0][NUM_RD-1:0]               err_q;
  logic [RD_LATENCY-1:0][NUM_RD-1:0][BUSWIDTH-1:0] dat_q;

  assign is_ready = (state_q == READY);
  assign wr_oor   = (bus.wr_addr >= DEPTH_A);
  assign wr_ok    = is_ready && bus.wr_en && !wr_oor;
  assign wr_idx   = bus.wr_addr[IW-1:0];

  // State register, clear counter and the registered out-of-range write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_err_q  <= is_ready && bus.wr_en && wr_oor;
    end
  end

  // Next state: sweep every word once, then serve requests until a clear is requested.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + IW'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end
      end
      READY: begin
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Merge the enabled write bytes over the word currently stored at the write address.
  always_comb begin
    wr_word = local_mem[wr_idx];
    for (int i = 0; i < NB; i++) begin
      if (bus.wr_be[i]) wr_word[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
  end

  // Sample each read port; in write-first mode a same-address write is forwarded.
  always_comb begin
    issue   = '0;
    rd_oor  = '0;
    rd_samp = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      issue[p]  = is_ready && bus.rd_en[p];
      rd_oor[p] = (bus.rd_addr[p] >= DEPTH_A);
      if (!rd_oor[p]) begin
        rd_samp[p] = local_mem[bus.rd_addr[p][IW-1:0]];
        if (WR_MODE == 1 && wr_ok && bus.rd_addr[p] == bus.wr_addr) rd_samp[p] = wr_word;
      end
    end
  end

  // Array update: the clear sweep has priority; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) local_mem[clr_cnt_q] <= '0;
      else if (wr_ok)       local_mem[wr_idx]    <= wr_word;
    end
  end

  // Read pipeline: data/err advance only with a valid, so the outputs hold between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= issue;
      for (int p = 0; p < NUM_RD; p++) begin
        if (issue[p]) begin
          dat_q[0][p] <= rd_samp[p];
          err_q[0][p] <= rd_oor[p];
        end
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        for (int p = 0; p < NUM_RD; p++) begin
          if (vld_q[k-1][p]) begin
            dat_q[k][p] <= dat_q[k-1][p];
            err_q[k][p] <= err_q[k-1][p];
          end
        end
      end
    end
  end

  assign bus.rd_valid = vld_q[RD_LATENCY-1];
  assign bus.rd_err   = err_q[RD_LATENCY-1];
  assign bus.rd_data  = dat_q[RD_LATENCY-1];
  assign bus.wr_err   = wr_err_q;
  assign bus.ready    = is_ready;
endmodule

// File: tb/tb_mem_mp.sv
// Bench for mem_mp: two instances (read-first/latency 1, write-first/latency 3) share one stimulus.
// A cycle-keyed scoreboard predicts every output; directed literals pin key values.
// No backpressure exists; requests made during a clear are expected to be dropped.
module tb_mem_mp;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rd_en;
  logic [1:0][31:0] rd_addr;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic             clr_req;

  mem_mp_if #(.NUM_RD(2), .ADDRWIDTH(32), .BUSWIDTH(32)) ifa ();
  mem_mp_if #(.NUM_RD(2), .ADDRWIDTH(32), .BUSWIDTH(32)) ifb ();

  assign ifa.rd_en = rd_en;   assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;
  assign ifa.wr_en = wr_en;   assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.wr_be = wr_be;   assign ifb.wr_be = wr_be;
  assign ifa.clr_req = clr_req; assign ifb.clr_req = clr_req;

  mem_mp #(.RAMDEPTH(D), .BUSWIDTH(32), .ADDRWIDTH(32), .NUM_RD(2), .RD_LATENCY(1), .WR_MODE(0))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_mp #(.RAMDEPTH(D), .BUSWIDTH(32), .ADDRWIDTH(32), .NUM_RD(2), .RD_LATENCY(3), .WR_MODE(1))
    u_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [1:0]            o_ready, o_wr_err;
  logic [1:0][1:0]       o_vld, o_err;
  logic [1:0][1:0][31:0] o_dat;
  assign o_ready[0] = ifa.ready;     assign o_ready[1] = ifb.ready;
  assign o_wr_err[0] = ifa.wr_err;   assign o_wr_err[1] = ifb.wr_err;
  assign o_vld[0] = ifa.rd_valid;    assign o_vld[1] = ifb.rd_valid;
  assign o_err[0] = ifa.rd_err;      assign o_err[1] = ifb.rd_err;
  assign o_dat[0] = ifa.rd_data;     assign o_dat[1] = ifb.rd_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [D];
  bit          m_ready = 1'b0;
  bit          exp_wr_err = 1'b0;
  int          clr_left = D;
  int          cyc = 0;
  int          pend_due [2][2][8];
  logic [31:0] pend_dat [2][2][8];
  bit          pend_err [2][2][8];
  logic [31:0] last_dat [2][2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  initial begin
    logic [31:0] merged, v;
    bit          wr_ok, rerr;
    int          slot;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < 8; s++) pend_due[d][p][s] = -1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ready = 1'b0; clr_left = D; exp_wr_err = 1'b0;
        for (int a = 0; a < D; a++) mem_m[a] = '0;
        for (int d = 0; d < 2; d++)
          for (int p = 0; p < 2; p++)
            for (int s = 0; s < 8; s++) pend_due[d][p][s] = -1;
      end else begin
        cyc++;
        exp_wr_err = 1'b0;
        if (m_ready) begin
          wr_ok  = wr_en && (wr_addr < D);
          exp_wr_err = wr_en && (wr_addr >= D);
          merged = '0;
          if (wr_ok) begin
            merged = mem_m[wr_addr[3:0]];
            for (int b = 0; b < 4; b++) if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
          end
          for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
              rerr = (rd_addr[p] >= D);
              for (int d = 0; d < 2; d++) begin
                v = rerr ? 32'h0 : mem_m[rd_addr[p][3:0]];
                if (d == 1 && wr_ok && rd_addr[p] == wr_addr) v = merged;
                slot = (cyc + lat(d) - 1) % 8;
                pend_due[d][p][slot] = cyc + lat(d) - 1;
                pend_dat[d][p][slot] = v;
                pend_err[d][p][slot] = rerr;
              end
            end
          end
          if (wr_ok) mem_m[wr_addr[3:0]] = merged;
          if (clr_req) begin
            m_ready = 1'b0; clr_left = D;
            for (int a = 0; a < D; a++) mem_m[a] = '0;
          end
        end else begin
          clr_left--;
          if (clr_left == 0) m_ready = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    int slot;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          chk($sformatf("rst_ready_%0d", d), 32'(o_ready[d]), 32'd0);
          chk($sformatf("rst_wr_err_%0d", d), 32'(o_wr_err[d]), 32'd0);
          for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst_vld_%0d_%0d", d, p), 32'(o_vld[d][p]), 32'd0);
            chk($sformatf("rst_dat_%0d_%0d", d, p), o_dat[d][p], 32'd0);
            last_dat[d][p] = '0;
          end
        end else begin
          chk($sformatf("ready_%0d@%0d", d, cyc), 32'(o_ready[d]), 32'(m_ready));
          chk($sformatf("wr_err_%0d@%0d", d, cyc), 32'(o_wr_err[d]), 32'(exp_wr_err));
          slot = cyc % 8;
          for (int p = 0; p < 2; p++) begin
            if (pend_due[d][p][slot] == cyc) begin
              chk($sformatf("vld_%0d_%0d@%0d", d, p, cyc), 32'(o_vld[d][p]), 32'd1);
              chk($sformatf("dat_%0d_%0d@%0d", d, p, cyc), o_dat[d][p], pend_dat[d][p][slot]);
              chk($sformatf("err_%0d_%0d@%0d", d, p, cyc), 32'(o_err[d][p]), 32'(pend_err[d][p][slot]));
              last_dat[d][p] = pend_dat[d][p][slot];
            end else begin
              chk($sformatf("novld_%0d_%0d@%0d", d, p, cyc), 32'(o_vld[d][p]), 32'd0);
              chk($sformatf("hold_%0d_%0d@%0d", d, p, cyc), o_dat[d][p], last_dat[d][p]);
            end
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rd_en = '0; wr_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic ready_count(input string name);
    for (int i = 1; i <= D; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s_a_%0d", name, i), 32'(ifa.ready), 32'(i == D));
      chk($sformatf("%s_b_%0d", name, i), 32'(ifb.ready), 32'(i == D));
    end
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] dt, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = dt; wr_be = be;
    tick();
    idle();
  endtask

  task automatic scan();
    for (int a = 0; a < D; a++) begin
      rd_en = 2'b11; rd_addr[0] = 32'(a); rd_addr[1] = 32'(D - 1 - a);
      tick();
    end
    idle();
    tick(); tick(); tick();
  endtask

  logic [31:0] p0_addr [4];
  logic [31:0] p1_addr [4];
  logic [31:0] p0_exp  [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    p0_addr = '{32'd3, 32'd5, 32'd4, 32'd0};
    p1_addr = '{32'd5, 32'd3, 32'd16, 32'd2};
    p0_exp  = '{32'h12345678, 32'hAA22CC44, 32'h77000000, 32'hCAFEF00D};
    idle(); rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    ready_count("ready_after_rst");
    scan();

    // Byte-enable merge.
    write(32'd5, 32'hAABBCCDD, 4'hF);
    write(32'd5, 32'h11223344, 4'h5);
    rd_en = 2'b01; rd_addr[0] = 32'd5;
    tick(); idle();
    @(negedge clk);
    chk("be_merge_a", ifa.rd_data[0], 32'hAA22CC44);
    tick(); tick();
    @(negedge clk);
    chk("be_merge_b", ifb.rd_data[0], 32'hAA22CC44);
    chk("be_merge_b_vld", 32'(ifb.rd_valid[0]), 32'd1);

    // Same-address collision on both ports.
    wr_en = 1'b1; wr_addr = 32'd3; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_en = 2'b11; rd_addr[0] = 32'd3; rd_addr[1] = 32'd3;
    tick(); idle();
    @(negedge clk);
    chk("coll_read_first_p0", ifa.rd_data[0], 32'h0);
    chk("coll_read_first_p1", ifa.rd_data[1], 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("coll_write_first_p0", ifb.rd_data[0], 32'h12345678);
    chk("coll_write_first_p1", ifb.rd_data[1], 32'h12345678);

    // Out-of-range read and write.
    rd_en = 2'b11; rd_addr[0] = 32'd16; rd_addr[1] = 32'd3;
    tick(); idle();
    @(negedge clk);
    chk("oor_rd_vld", 32'(ifa.rd_valid[0]), 32'd1);
    chk("oor_rd_err", 32'(ifa.rd_err[0]), 32'd1);
    chk("oor_rd_dat", ifa.rd_data[0], 32'h0);
    chk("rd_after_wr", ifa.rd_data[1], 32'h12345678);
    wr_en = 1'b1; wr_addr = 32'd20; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    tick(); idle();
    @(negedge clk);
    chk("oor_wr_err_a", 32'(ifa.wr_err), 32'd1);
    chk("oor_wr_err_b", 32'(ifb.wr_err), 32'd1);
    tick();
    @(negedge clk);
    chk("oor_wr_err_pulse", 32'(ifa.wr_err), 32'd0);
    rd_en = 2'b01; rd_addr[0] = 32'd4;
    tick(); idle();
    @(negedge clk);
    chk("oor_wr_no_alias", ifa.rd_data[0], 32'h0);
    scan();

    // Back-to-back pipelined reads.
    write(32'd0, 32'hCAFEF00D, 4'hF);
    write(32'd2, 32'h1234BEEF, 4'h3);
    write(32'd4, 32'h77665544, 4'h8);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        rd_en = 2'b11; rd_addr[0] = p0_addr[i]; rd_addr[1] = p1_addr[i];
      end else begin
        idle();
      end
      tick();
      @(negedge clk);
      chk($sformatf("pipe_vld_b_%0d", i), 32'(ifb.rd_valid[0]), 32'(i >= 2 && i <= 5));
      chk($sformatf("pipe_vld_a_%0d", i), 32'(ifa.rd_valid[1]), 32'(i <= 3));
      if (i >= 2 && i <= 5) chk($sformatf("pipe_dat_b_%0d", i), ifb.rd_data[0], p0_exp[i-2]);
    end
    idle();

    // Clear request with a read in flight, then reset part-way through the sweep.
    rd_en = 2'b01; rd_addr[0] = 32'd5; clr_req = 1'b1;
    tick(); idle();
    @(negedge clk);
    chk("clr_ready_fall", 32'(ifa.ready), 32'd0);
    chk("clr_inflight_a", ifa.rd_data[0], 32'hAA22CC44);
    tick(); tick();
    @(negedge clk);
    chk("clr_inflight_b", ifb.rd_data[0], 32'hAA22CC44);
    chk("clr_inflight_b_vld", 32'(ifb.rd_valid[0]), 32'd1);
    wr_en = 1'b1; wr_addr = 32'd1; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 2'b11; rd_addr = '0;
    repeat (5) tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_count("ready_after_midclear_rst");
    rd_en = 2'b11; rd_addr[0] = 32'd5; rd_addr[1] = 32'd1;
    tick(); idle();
    @(negedge clk);
    chk("cleared_5", ifa.rd_data[0], 32'h0);
    chk("cleared_1", ifa.rd_data[1], 32'h0);
    chk("cleared_vld", 32'(ifa.rd_valid), 32'd3);

    // Reset while reads are still inside the latency-3 pipeline.
    write(32'd6, 32'h5A5A5A5A, 4'hF);
    rd_en = 2'b11; rd_addr[0] = 32'd6; rd_addr[1] = 32'd3;
    tick(); idle();
    rst = 1'b1;
    @(negedge clk);
    chk("flush_vld_b", 32'(ifb.rd_valid), 32'd0);
    chk("flush_dat_a", ifa.rd_data[0], 32'h0);
    tick();
    rst = 1'b0;
    ready_count("ready_after_flush");
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
